// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port (controller C, debug/loader D) arbiter for the single-port data memory
module dmem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              prio_fixed,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic [1:0] {IDLE, OWN_C, OWN_D} owner_t;

  owner_t            owner, owner_nxt;
  logic              last_d;
  logic [7:0]        burst_cnt;
  logic [RD_LAT-1:0] rd_v, rd_own_d;
  logic [DATA_W-1:0] c_rdata_q, d_rdata_q;
  logic              conflict;

  always_ff @(posedge clock) begin
    if (reset) owner <= IDLE;
    else       owner <= owner_nxt;
  end

  // Grant decision; while reset is high nothing is granted.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (prio_fixed) begin
        c_gnt = c_req;
        d_gnt = d_req && !c_req;
      end else if (owner == OWN_D && d_req && d_lock && burst_cnt < 8'(MAX_BURST)) begin
        d_gnt = 1'b1;
      end else if (c_req && d_req) begin
        c_gnt = last_d;
        d_gnt = !last_d;
      end else begin
        c_gnt = c_req;
        d_gnt = d_req;
      end
    end
    owner_nxt = c_gnt ? OWN_C : (d_gnt ? OWN_D : IDLE);
  end

  always_comb begin
    mem_wr    = (c_gnt && c_we) || (d_gnt && d_we);
    mem_rd    = (c_gnt && !c_we) || (d_gnt && !d_we);
    mem_addr  = c_gnt ? c_addr  : (d_gnt ? d_addr  : '0);
    mem_wdata = c_gnt ? c_wdata : (d_gnt ? d_wdata : '0);
  end

  assign conflict = (c_req && !c_gnt) || (d_req && !d_gnt);

  always_ff @(posedge clock) begin
    if (reset) begin
      last_d       <= 1'b1;
      burst_cnt    <= 8'd0;
      conflict_cnt <= 16'd0;
    end else begin
      if (c_gnt)      last_d <= 1'b0;
      else if (d_gnt) last_d <= 1'b1;
      if (c_gnt || !c_req)               burst_cnt <= 8'd0;
      else if (d_gnt && burst_cnt != 8'hFF) burst_cnt <= burst_cnt + 8'd1;
      if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  // Owner shift register: tags each issued read with its requester.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_v     <= '0;
      rd_own_d <= '0;
    end else begin
      rd_v[0]     <= mem_rd;
      rd_own_d[0] <= d_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_v[i]     <= rd_v[i-1];
        rd_own_d[i] <= rd_own_d[i-1];
      end
    end
  end

  assign c_rvalid = !reset && rd_v[RD_LAT-1] && !rd_own_d[RD_LAT-1];
  assign d_rvalid = !reset && rd_v[RD_LAT-1] &&  rd_own_d[RD_LAT-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (c_rvalid) c_rdata_q <= mem_rdata;
      if (d_rvalid) d_rdata_q <= mem_rdata;
    end
  end

  assign c_rdata = c_rvalid ? mem_rdata : c_rdata_q;
  assign d_rdata = d_rvalid ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench for dmem_arbiter with a 256x16 memory model
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        prio_fixed;
  logic        c_req, c_we, d_req, d_we, d_lock;
  logic [7:0]  c_addr, d_addr;
  logic [15:0] c_wdata, d_wdata;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [15:0] c_rdata, d_rdata;
  logic [7:0]  mem_addr;
  logic        mem_wr, mem_rd;
  logic [15:0] mem_wdata, mem_rdata;
  logic [15:0] conflict_cnt;

  logic [15:0] mem [256];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1), .MAX_BURST(8)) dut (
    .clock(clock), .reset(reset), .prio_fixed(prio_fixed),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  // Memory model: write-then-read, one-cycle read latency.
  always @(posedge clock) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_lock = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1; idle_inputs();
    @(negedge clock);
    reset = 0;
  endtask

  initial begin
    int  da;
    logic c_was, d_was;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h10] = 16'h1234;
    mem_rdata = 16'h0;
    prio_fixed = 0;
    idle_inputs();
    reset = 1;
    c_req = 1; d_req = 1;
    #2;
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_c_rvalid", c_rvalid, 0);
    @(negedge clock);
    #2;
    chk("rst_conflict", conflict_cnt, 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(negedge clock);
    reset = 0; idle_inputs();

    // Single C read of 0x10
    @(negedge clock);
    c_req = 1; c_addr = 8'h10;
    #2;
    chk("rd_c_gnt", c_gnt, 1);
    chk("rd_d_gnt", d_gnt, 0);
    chk("rd_mem_rd", mem_rd, 1);
    chk("rd_mem_addr", mem_addr, 8'h10);
    @(negedge clock);
    c_req = 0;
    #2;
    chk("rd_c_rvalid", c_rvalid, 1);
    chk("rd_c_rdata", c_rdata, 16'h1234);
    chk("rd_d_rvalid", d_rvalid, 0);
    @(negedge clock);
    #2;
    chk("rd_c_rvalid_once", c_rvalid, 0);
    chk("rd_c_rdata_hold", c_rdata, 16'h1234);

    // Round-robin tie: C, D, C, D with one conflict per cycle
    do_reset();
    @(negedge clock);
    c_req = 1; c_addr = 8'h10; d_req = 1; d_addr = 8'h10;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      #2;
      chk("rr_conflict", conflict_cnt, i);
      chk("rr_c_gnt", c_gnt, (i % 2 == 0));
      chk("rr_d_gnt", d_gnt, (i % 2 == 1));
    end
    @(negedge clock);
    idle_inputs();
    #2;
    chk("rr_conflict_end", conflict_cnt, 4);

    // Locked D burst bounded by MAX_BURST
    do_reset();
    @(negedge clock);
    d_req = 1; d_lock = 1; d_we = 1; d_addr = 0; d_wdata = 16'hA000;
    #2;
    chk("bl_first_d", d_gnt, 1);
    da = 1;
    c_was = 0;
    @(negedge clock);
    c_req = 1; c_we = 0; c_addr = 8'h10;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        @(negedge clock);
        if (c_was) c_req = 0;
        if (d_was) da++;
      end
      d_addr = 8'(da); d_wdata = 16'hA000 + 16'(da);
      #2;
      chk("bl_c_gnt", c_gnt, (i == 8));
      chk("bl_d_gnt", d_gnt, (i != 8));
      c_was = c_gnt;
      d_was = d_gnt;
    end
    @(negedge clock);
    idle_inputs();
    #2;
    chk("bl_mem_wrote", mem[8'h05], 16'hA005);

    // Fixed priority beats lock
    do_reset();
    @(negedge clock);
    prio_fixed = 1;
    c_req = 1; c_addr = 8'h10; d_req = 1; d_lock = 1; d_we = 1; d_addr = 8'h30;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clock);
      #2;
      chk("pf_c_gnt", c_gnt, 1);
      chk("pf_d_gnt", d_gnt, 0);
    end
    @(negedge clock);
    idle_inputs(); prio_fixed = 0;
    #2;
    chk("pf_conflict", conflict_cnt, 10);

    // D write then C read same address
    do_reset();
    @(negedge clock);
    d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 16'hBEEF;
    #2;
    chk("wr_d_gnt", d_gnt, 1);
    chk("wr_mem_wr", mem_wr, 1);
    @(negedge clock);
    idle_inputs();
    c_req = 1; c_addr = 8'h20;
    #2;
    chk("wr_c_gnt", c_gnt, 1);
    @(negedge clock);
    c_req = 0;
    #2;
    chk("wr_c_rvalid", c_rvalid, 1);
    chk("wr_c_rdata", c_rdata, 16'hBEEF);

    // Reset mid-read discards the pending return
    @(negedge clock);
    c_req = 1; c_addr = 8'h10;
    #2;
    chk("mr_c_gnt", c_gnt, 1);
    @(negedge clock);
    c_req = 0; reset = 1;
    #2;
    chk("mr_rvalid_in_rst", c_rvalid, 0);
    @(negedge clock);
    reset = 0;
    #2;
    chk("mr_rvalid_after", c_rvalid, 0);
    chk("mr_c_rdata", c_rdata, 0);
    chk("mr_mem_wr", mem_wr, 0);
    chk("mr_mem_rd", mem_rd, 0);
    chk("mr_mem_wdata", mem_wdata, 0);
    chk("mr_conflict", conflict_cnt, 0);
    @(negedge clock);
    c_req = 1; c_addr = 8'h10; d_req = 1; d_addr = 8'h11;
    #2;
    chk("mr_tie_c", c_gnt, 1);
    chk("mr_tie_d", d_gnt, 0);
    @(negedge clock);
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 256x16 data memory between the processor controller (port C) and the debug/program-loader port (port D).
- One memory access is issued per cycle, pipelined. Read data returns to the requester that issued the read after a fixed latency.
- Arbitration is round-robin by default, with a fixed-priority mode and a bounded burst lock for port D.
- Sits between the controller's d_addr/d_wr path and the data memory instance.

Parameters:
- ADDR_W, 8, data memory address width.
- DATA_W, 16, data word width.
- RD_LAT, 1, memory read latency in cycles; legal values 1 or 2.
- MAX_BURST, 8, maximum consecutive locked grants to port D while port C is waiting; legal range 1..255.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- prio_fixed  in  1  1 = port C always wins when requesting; 0 = round-robin
- c_req  in  1  port C access request
- c_we  in  1  port C write (1) / read (0)
- c_addr  in  ADDR_W  port C address
- c_wdata  in  DATA_W  port C write data
- c_gnt  out  1  port C request accepted this cycle
- c_rvalid  out  1  port C read data valid
- c_rdata  out  DATA_W  port C read data
- d_req, d_we, d_addr, d_wdata  in  1/1/ADDR_W/DATA_W  port D equivalents of the C request signals
- d_lock  in  1  port D requests to keep ownership on consecutive cycles
- d_gnt, d_rvalid, d_rdata  out  1/1/DATA_W  port D equivalents of the C response signals
- mem_addr  out  ADDR_W  memory address
- mem_wr  out  1  memory write enable
- mem_rd  out  1  memory read enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_rd
- conflict_cnt  out  16  saturating count of cycles in which a requester was denied

Behaviour:
- Handshake
  - A requester holds req, we, addr and wdata stable until it sees gnt=1 in the same cycle.
  - gnt is combinational from req and registered arbiter state.
  - At most one gnt is high per cycle.
  - A granted access is driven onto mem_* in the same cycle.
  - With no grant: mem_wr=0, mem_rd=0, mem_addr=0, mem_wdata=0.
- Read return
  - A granted read sets mem_rd=1.
  - An RD_LAT-deep owner shift register returns mem_rdata on the owner's rdata, with its rvalid=1 for exactly one cycle, RD_LAT cycles later.
  - The non-owner's rdata holds its last value.
  - Writes produce no rvalid.
- Arbiter state
  - owner register holds IDLE, OWN_C or OWN_D (last granted port).
  - burst_cnt is 8 bits.
  - Next owner = granted port, or IDLE when neither port is granted.
- Grant rules, in priority order:
  1. prio_fixed=1: c_req wins whenever asserted; otherwise d_req wins.
  2. owner=OWN_D, d_req=1, d_lock=1 and burst_cnt<MAX_BURST: D wins, even if c_req=1.
  3. Only one port requesting: that port wins.
  4. Both requesting: the port that is not the last granted wins. Last granted is tracked separately from owner and survives IDLE. Its reset value is D, so C wins the first tie.
- burst_cnt
  - Increments on each D grant made while c_req=1.
  - Clears on any C grant, or any cycle with c_req=0.
  - Saturates at 255.
  - When burst_cnt=MAX_BURST, the lock is ignored and C wins the next cycle.
- conflict_cnt increments by 1 in any cycle where a req is high without its gnt; it saturates at 16'hFFFF.
- Same-address ordering: writes take effect in grant order. A read granted the cycle after a write to the same address returns the new data; this relies on memory write-then-read semantics.
- Reset, including mid-operation:
  - owner=IDLE, last=D, burst_cnt=0, conflict_cnt=0.
  - All gnt/rvalid = 0, rdata = 0, mem_* = 0.
  - In-flight reads are discarded and no rvalid is produced after reset.
  - While reset=1, no grant is given, even if requests are high.

Test Plan:
- Reset, then c_req=1 read addr 8'h10 (mem holds 16'h1234) -> c_gnt=1 same cycle, mem_rd=1, mem_addr=8'h10; c_rvalid=1 with c_rdata=16'h1234 exactly RD_LAT cycles later; d_rvalid stays 0.
- c_req and d_req both high continuously, no lock, prio_fixed=0 -> grants alternate C,D,C,D starting with C; conflict_cnt increments by 1 per cycle.
- d_req=1, d_lock=1 writing addr 0..15 while c_req=1, MAX_BURST=8 -> D granted 8 consecutive cycles, then C granted, then D resumes; no cycle has both gnts high.
- prio_fixed=1, both requesting with d_lock=1 for 10 cycles -> c_gnt=1 every cycle, d_gnt=0, conflict_cnt=10.
- D writes 16'hBEEF to 8'h20; C reads 8'h20 the next cycle -> c_rdata=16'hBEEF.
- C read granted, reset asserted in the next cycle for 1 cycle -> no c_rvalid ever; after reset all outputs 0 and a tie grants C first.
